// File: rtl/hc_pkg.sv
// Types and helpers shared by the hash requestor, the lane dispatcher and the hash cores.
package hc_pkg;
   localparam int HC_LANE_MAX = 16;

   typedef logic [511:0]                   t_hc_block;
   typedef logic [127:0]                   t_hc_digest;
   typedef logic [$clog2(HC_LANE_MAX)-1:0] t_hc_lane;

   // A zero or out-of-range request means "use every lane".
   function automatic logic [4:0] hc_clamp_lanes(input logic [4:0] cfg, input logic [4:0] max_lanes);
      return (cfg == 5'd0 || cfg > max_lanes) ? max_lanes : cfg;
   endfunction

   function automatic t_hc_lane hc_next_lane(input t_hc_lane ptr, input logic [4:0] n_act);
      return ({1'b0, ptr} >= n_act - 5'd1) ? '0 : ptr + t_hc_lane'(1);
   endfunction
endpackage

// File: rtl/hc_sync_fifo.sv
// First-word-fall-through result FIFO; a write while full is dropped unless a pop frees a slot that cycle.
module hc_sync_fifo #(
   parameter int WIDTH = 128,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_wr,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_rd,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_full,
   output logic             o_empty,
   output logic             o_overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full     = (r_count == FULL_COUNT);
   assign o_empty    = (r_count == '0);
   assign w_pop      = i_rd && !o_empty;
   assign w_push     = i_wr && (!o_full || w_pop);
   assign o_overflow = i_wr && !w_push;
   assign o_rd_data  = r_mem[r_rptr];

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= i_wr_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
         else if (!w_push && w_pop) r_count <= r_count - (AW+1)'(1);
      end
   end
endmodule

// File: rtl/hc_hash_dispatch.sv
// Round-robin dispatcher over NUM_LANES hash cores; digests return to the requestor in input order.
module hc_hash_dispatch
   import hc_pkg::*;
#(
   parameter int NUM_LANES      = 4,
   parameter int DATA_IN_WIDTH  = 512,
   parameter int DATA_OUT_WIDTH = 128,
   parameter int FIFO_DEPTH     = 8
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic [4:0]                          cfg_lanes,
   input  logic [DATA_IN_WIDTH-1:0]            in_data,
   input  logic                                in_valid,
   output logic                                in_ready,
   output logic [NUM_LANES*DATA_IN_WIDTH-1:0]  lane_data_out,
   output logic [NUM_LANES-1:0]                lane_valid_out,
   input  logic [NUM_LANES-1:0]                lane_ready,
   input  logic [NUM_LANES*DATA_OUT_WIDTH-1:0] lane_data_in,
   input  logic [NUM_LANES-1:0]                lane_valid_in,
   output logic [DATA_OUT_WIDTH-1:0]           out_data,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic                                busy,
   output logic                                overflow_err
);
   localparam int         CW        = $clog2(FIFO_DEPTH) + 1;
   localparam logic [4:0] LANES_MAX = 5'(NUM_LANES);

   logic [4:0]                          r_n_act;
   logic [4:0]                          w_cfg_n;
   logic [4:0]                          w_n_eff;
   t_hc_lane                            r_dptr;
   t_hc_lane                            r_cptr;
   t_hc_lane                            w_dptr_eff;
   logic                                r_overflow;
   logic                                w_idle;
   logic                                w_reload;
   logic                                w_in_fire;
   logic                                w_out_fire;
   logic                                w_sel_empty;
   logic [NUM_LANES-1:0]                w_lane_valid;
   logic [NUM_LANES-1:0]                w_credit_nz;
   logic [NUM_LANES-1:0]                w_credit_room;
   logic [NUM_LANES-1:0]                w_empty;
   logic [NUM_LANES-1:0]                w_lane_ovf;
   logic [NUM_LANES*DATA_OUT_WIDTH-1:0] w_heads;

   assign w_cfg_n  = hc_clamp_lanes(cfg_lanes, LANES_MAX);
   assign w_idle   = !(|w_credit_nz) && !(|w_lane_valid);
   // A new lane count restarts both rotations at lane 0 so dispatch never lands outside the active set.
   assign w_reload   = w_idle && (w_cfg_n != r_n_act);
   assign w_n_eff    = w_reload ? w_cfg_n : r_n_act;
   assign w_dptr_eff = w_reload ? '0 : r_dptr;

   always_comb begin
      in_ready    = 1'b0;
      w_sel_empty = 1'b1;
      out_data    = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (w_dptr_eff == t_hc_lane'(i))
            in_ready = (!w_lane_valid[i] || lane_ready[i]) && w_credit_room[i];
         if (r_cptr == t_hc_lane'(i)) begin
            w_sel_empty = w_empty[i];
            out_data    = w_heads[i*DATA_OUT_WIDTH +: DATA_OUT_WIDTH];
         end
      end
   end

   assign out_valid      = !w_sel_empty;
   assign w_in_fire      = in_valid && in_ready;
   assign w_out_fire     = out_valid && out_ready;
   assign busy           = |w_credit_nz;
   assign overflow_err   = r_overflow;
   assign lane_valid_out = w_lane_valid;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_n_act    <= LANES_MAX;
         r_dptr     <= '0;
         r_cptr     <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_idle) r_n_act <= w_cfg_n;
         if (w_in_fire)     r_dptr <= hc_next_lane(w_dptr_eff, w_n_eff);
         else if (w_reload) r_dptr <= '0;
         if (w_out_fire)    r_cptr <= hc_next_lane(r_cptr, r_n_act);
         else if (w_reload) r_cptr <= '0;
         if (|w_lane_ovf) r_overflow <= 1'b1;
      end
   end

   for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic                     w_disp;
      logic                     w_pop;
      logic                     r_valid;
      logic [CW-1:0]            r_credit;
      logic [DATA_IN_WIDTH-1:0] r_data;

      assign w_disp = w_in_fire && (w_dptr_eff == t_hc_lane'(gi));
      assign w_pop  = w_out_fire && (r_cptr == t_hc_lane'(gi));

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            r_valid  <= 1'b0;
            r_credit <= '0;
         end else begin
            if (w_disp)              r_valid <= 1'b1;
            else if (lane_ready[gi]) r_valid <= 1'b0;
            // Stray digests can be popped with no credit behind them; never wrap below zero.
            if (w_disp && !w_pop)                          r_credit <= r_credit + CW'(1);
            else if (!w_disp && w_pop && r_credit != '0)   r_credit <= r_credit - CW'(1);
         end
      end

      always_ff @(posedge clk) begin
         if (w_disp) r_data <= in_data;
      end

      assign lane_data_out[gi*DATA_IN_WIDTH +: DATA_IN_WIDTH] = r_data;
      assign w_lane_valid[gi]  = r_valid;
      assign w_credit_nz[gi]   = (r_credit != '0);
      assign w_credit_room[gi] = (r_credit < CW'(FIFO_DEPTH));

      hc_sync_fifo #(
         .WIDTH (DATA_OUT_WIDTH),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk        (clk),
         .reset_n    (reset_n),
         .i_wr       (lane_valid_in[gi]),
         .i_wr_data  (lane_data_in[gi*DATA_OUT_WIDTH +: DATA_OUT_WIDTH]),
         .i_rd       (w_pop),
         .o_rd_data  (w_heads[gi*DATA_OUT_WIDTH +: DATA_OUT_WIDTH]),
         .o_full     (),
         .o_empty    (w_empty[gi]),
         .o_overflow (w_lane_ovf[gi])
      );
   end
endmodule

// File: doc/hc_hash_dispatch.md
# hc_hash_dispatch

Parametrised lane dispatcher between the hash requestor and N hash cores. It replaces the single fixed requestor→core→requestor loop with a dispatcher that spreads 512-bit input blocks round-robin over `NUM_LANES` cores. Each lane's digests are buffered per lane and returned to the requestor in strict input order, with valid/ready backpressure on both sides. The block sits in the AFU clock domain, between the requestor and the core array.

## Interface
Parameters:
- `NUM_LANES`, 4: number of hash cores; 1..16.
- `DATA_IN_WIDTH`, 512: input block width, one cache line.
- `DATA_OUT_WIDTH`, 128: digest width.
- `FIFO_DEPTH`, 8: result FIFO entries per lane; power of two ≥ 2. Also the lane's maximum outstanding count.

Ports:
- `clk`  in  1  AFU clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cfg_lanes`  in  5  requested active lane count.
- `in_data`  in  DATA_IN_WIDTH  block from the requestor.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  dispatcher accepts `in_data` this cycle.
- `lane_data_out`  out  NUM_LANES×DATA_IN_WIDTH  per-lane block to a core.
- `lane_valid_out`  out  NUM_LANES  per-lane block valid.
- `lane_ready`  in  NUM_LANES  core accepts its block.
- `lane_data_in`  in  NUM_LANES×DATA_OUT_WIDTH  per-lane digest.
- `lane_valid_in`  in  NUM_LANES  digest valid; single-cycle pulse, no backpressure.
- `out_data`  out  DATA_OUT_WIDTH  ordered digest to the requestor.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  requestor consumes `out_data`.
- `busy`  out  1  any block is outstanding.
- `overflow_err`  out  1  sticky flag: a digest arrived for a full FIFO.

## Operation
- **Transfer rule:** a transfer occurs when valid and ready are both high in the same cycle. A valid signal is never dropped until its transfer occurs.
- **Active lane count:** the latched lane count `n_act` loads from `cfg_lanes` only while the block is idle. Idle means all credits are 0 and no `lane_valid_out` is set. A value of 0 or more than `NUM_LANES` clamps to `NUM_LANES`. Changes to `cfg_lanes` while busy are ignored.
- **Dispatch pointer:** `dptr` starts at 0. It advances by one on each input transfer and wraps from `n_act-1` to 0.
- **Credits:** `credit[i]` counts blocks sent to lane i whose digests have not yet left on `out_*`.
- **Input acceptance:** `in_ready = (!lane_valid_out[dptr] || lane_ready[dptr]) && credit[dptr] < FIFO_DEPTH`.
- **Input transfer:** loads the lane i=`dptr` output register, sets `lane_valid_out[i]`, and increments `credit[i]`.
- **Lane handoff:** `lane_valid_out[i]` clears after a transfer on lane i unless a new block loads the register in the same cycle.
- **Results:** a digest pulse on `lane_valid_in[i]` writes lane i's result FIFO.
  - If that FIFO is full, the write is dropped and `overflow_err` is set. The error clears only on reset.
- **Collect pointer:** `cptr` starts at 0. `out_valid = !empty[cptr]`, and `out_data` is the head of FIFO `cptr`. This holds even if other lanes' FIFOs are non-empty.
- **Output transfer:** pops FIFO `cptr`, decrements `credit[cptr]`, and advances `cptr`, wrapping from `n_act-1` to 0.
- **Ordering:** because dispatch and collect follow the same round-robin sequence, output order equals input order.
- **Same-cycle events on one lane:** a dispatch and an output transfer on the same lane net to no change in that lane's credit. A FIFO write and pop in the same cycle are both honoured; when the FIFO is full, the pop makes room, so no overflow occurs.
- **`busy`:** `busy = OR(credit[i] != 0)`.

## Timing
- **Reset values:** all valids 0, `dptr`/`cptr` 0, credits 0, FIFOs empty, `overflow_err` 0, `busy` 0, and `n_act = NUM_LANES`.
- **Reset during operation:** all in-flight blocks and digests are discarded. The cores share `reset_n`, so they drop their work too.
- **Input latency:** `lane_valid_out` rises one cycle after the input transfer.
- **Result latency:** `out_valid` rises one cycle after the `lane_valid_in` pulse when lane `cptr` matches.
- **Combinational paths:** `in_ready` depends combinationally on `lane_ready[dptr]`. `out_valid`/`out_data` are driven from flops only.
- **Throughput:** with all lanes ready, one block per cycle in and one digest per cycle out.

## Structure
- **Shared package:** `hc_pkg` holds `HC_LANE_MAX` (16), `t_hc_block` (512 bits), `t_hc_digest` (128 bits) and the lane-index typedef. The requestor and cores import it too.
- **Sub-module:** `hc_sync_fifo` (parameters `WIDTH`, `DEPTH`; first-word-fall-through, with full/empty flags), instantiated once per lane.
- **Top module:** `hc_hash_dispatch` keeps the pointers, credit counters, lane output registers and the `n_act` latch.

## Test plan
- **Ordered round-trip:** `NUM_LANES`=4, `cfg_lanes`=4. Send 12 blocks tagged 0..11; the cores reply with random latencies of 1..20 cycles → `out_data` carries tags 0..11 in order, then `busy`=0.
- **Credit stall:** `FIFO_DEPTH`=8, `out_ready`=0. Send 40 blocks → exactly 32 accepted, `in_ready`=0 once lane `dptr` reaches credit 8, no `overflow_err`.
- **Partial lanes:** `cfg_lanes`=3 while idle. Send 6 blocks → lane order 0,1,2,0,1,2; lane 3 never sees `lane_valid_out`. `cfg_lanes`=0 → all 4 lanes used.
- **Config while busy:** change `cfg_lanes` to 1 while 5 blocks are outstanding → rotation stays at 4 lanes until idle, then only lane 0 is used.
- **Overflow:** inject 9 spurious `lane_valid_in[2]` pulses with `out_ready`=0 → `overflow_err`=1 on the 9th and stays 1.
- **Reset mid-stream:** assert `reset_n` low with 6 blocks outstanding → next cycle all valids 0 and `busy`=0; a fresh block after release is dispatched to lane 0.
